vga_char_buf_ctrl: RTL

- Owns the 36-entry character buffer that feeds the 3-row x 12-column VGA text renderer. Renderer inputs char_1..char_36 are driven from the chars bus.
- Arbitrates writes between two requesters: the CPU MMIO port and the debug/monitor port.
- Double-buffers the text. Writes land in a shadow copy, and the shadow is committed to the live copy only at frame start (vertical blank), so no frame shows a partial update.
- Provides a hardware clear-screen sequence.

---
 rtl/vga_text_pkg.sv | 20 ++
 rtl/vga_char_buf_ctrl_if.sv | 29 ++
 rtl/vga_rr_arb2.sv | 38 +++
 rtl/vga_char_buf_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// Shared constants and enums for the VGA text character buffer controller.
package vga_text_pkg;

  localparam int unsigned NUM_CHARS = 36;
  localparam int unsigned CHAR_W    = 8;
  localparam int unsigned ADDR_W    = 6;

  localparam logic [CHAR_W-1:0] BLANK_CHAR = 8'h20;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef enum logic {
    CPU = 1'b0,
    DBG = 1'b1
  } req_id_e;

endpackage

// File: rtl/vga_char_buf_ctrl_if.sv
// Bus bundle for vga_char_buf_ctrl: two write requesters, clear/frame controls, live character bus.
interface vga_char_buf_ctrl_if;
  import vga_text_pkg::*;

  logic                        cpu_req;
  logic [ADDR_W-1:0]           cpu_addr;
  logic [CHAR_W-1:0]           cpu_data;
  logic                        cpu_ack;
  logic                        dbg_req;
  logic [ADDR_W-1:0]           dbg_addr;
  logic [CHAR_W-1:0]           dbg_data;
  logic                        dbg_ack;
  logic                        clr_req;
  logic                        frame_start;
  logic [NUM_CHARS*CHAR_W-1:0] chars;
  logic                        busy;
  logic                        addr_err;

  modport master (
    output cpu_req, cpu_addr, cpu_data, dbg_req, dbg_addr, dbg_data, clr_req, frame_start,
    input  cpu_ack, dbg_ack, chars, busy, addr_err
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_data, dbg_req, dbg_addr, dbg_data, clr_req, frame_start,
    output cpu_ack, dbg_ack, chars, busy, addr_err
  );

endinterface

// File: rtl/vga_rr_arb2.sv
// Two-input round-robin arbiter; bit 0 = CPU, bit 1 = DBG. A requester whose ack is high is masked.
module vga_rr_arb2
  import vga_text_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  input  logic [1:0] i_ack_mask,
  output logic [1:0] o_grant
);

  req_id_e    r_last_grant;
  logic [1:0] w_elig;

  assign w_elig = i_en ? (i_req & ~i_ack_mask) : 2'b00;

  always_comb begin
    o_grant = 2'b00;
    unique case (w_elig)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (r_last_grant == DBG) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= DBG;
    end else if (o_grant[0]) begin
      r_last_grant <= CPU;
    end else if (o_grant[1]) begin
      r_last_grant <= DBG;
    end
  end

endmodule

// File: rtl/vga_char_buf_ctrl.sv
// Double-buffered 36-cell character store with CPU/debug write arbitration and clear-screen.
// Define VGA_CHAR_BUF_DIRECT_EN to drop the shadow copy and write the live cells directly.
module vga_char_buf_ctrl
  import vga_text_pkg::*;
(
  input logic                clk,
  input logic                rst,
  vga_char_buf_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_CHARS - 1);
  localparam logic [ADDR_W-1:0] NumIdx  = ADDR_W'(NUM_CHARS);

  state_e            r_state;
  logic [ADDR_W-1:0] r_clr_idx;
  logic              r_busy;
  logic              r_cpu_ack;
  logic              r_dbg_ack;
  logic              r_addr_err;
  logic [CHAR_W-1:0] r_live [NUM_CHARS];
`ifndef VGA_CHAR_BUF_DIRECT_EN
  logic [CHAR_W-1:0] r_shadow [NUM_CHARS];
  logic              r_dirty;
`endif

  logic [1:0]        w_grant;
  logic              w_wr_en;
  logic              w_addr_ok;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [CHAR_W-1:0] w_wr_data;

  vga_rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_en       (r_state == IDLE),
    .i_req      ({bus.dbg_req, bus.cpu_req}),
    .i_ack_mask ({r_dbg_ack, r_cpu_ack}),
    .o_grant    (w_grant)
  );

  assign w_wr_en   = |w_grant;
  assign w_wr_addr = w_grant[1] ? bus.dbg_addr : bus.cpu_addr;
  assign w_wr_data = w_grant[1] ? bus.dbg_data : bus.cpu_data;
  assign w_addr_ok = w_wr_addr < NumIdx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_clr_idx  <= '0;
      r_busy     <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_dbg_ack  <= 1'b0;
      r_addr_err <= 1'b0;
      for (int i = 0; i < NUM_CHARS; i++) begin
        r_live[i] <= BLANK_CHAR;
`ifndef VGA_CHAR_BUF_DIRECT_EN
        r_shadow[i] <= BLANK_CHAR;
`endif
      end
`ifndef VGA_CHAR_BUF_DIRECT_EN
      r_dirty <= 1'b0;
`endif
    end else begin
      r_cpu_ack  <= w_grant[0];
      r_dbg_ack  <= w_grant[1];
      r_addr_err <= w_wr_en && !w_addr_ok;
      unique case (r_state)
        IDLE: begin
`ifndef VGA_CHAR_BUF_DIRECT_EN
          // Commit takes pre-edge shadow; a same-edge write below lands in shadow and re-dirties.
          if (bus.frame_start && r_dirty) begin
            r_live  <= r_shadow;
            r_dirty <= 1'b0;
          end
          if (w_wr_en && w_addr_ok) begin
            r_shadow[w_wr_addr] <= w_wr_data;
            r_dirty             <= 1'b1;
          end
`else
          if (w_wr_en && w_addr_ok) begin
            r_live[w_wr_addr] <= w_wr_data;
          end
`endif
          if (bus.clr_req) begin
            r_state   <= CLEAR;
            r_busy    <= 1'b1;
            r_clr_idx <= '0;
          end
        end
        CLEAR: begin
`ifndef VGA_CHAR_BUF_DIRECT_EN
          r_shadow[r_clr_idx] <= BLANK_CHAR;
`else
          r_live[r_clr_idx] <= BLANK_CHAR;
`endif
          if (r_clr_idx == LastIdx) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
`ifndef VGA_CHAR_BUF_DIRECT_EN
            r_dirty <= 1'b1;
`endif
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.chars = '0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      bus.chars[i*CHAR_W +: CHAR_W] = r_live[i];
    end
  end

  assign bus.cpu_ack  = r_cpu_ack;
  assign bus.dbg_ack  = r_dbg_ack;
  assign bus.busy     = r_busy;
  assign bus.addr_err = r_addr_err;

endmodule
